// File: rtl/spi_slave_ctrl_if.sv
// spi_slave_ctrl_if: host-side stream bundle of the SPI slave controller.
//   tx_data_i/tx_valid_i/tx_ready_o : outbound word handshake (host -> controller)
//   rx_data_o/rx_err_o/rx_valid_o/rx_ready_i : captured frame stream (controller -> host)
//   ovf_o : one-cycle pulse when an unconsumed rx word is overwritten
`timescale 1ns/1ps
interface spi_slave_ctrl_if #(
    parameter int IO_COUNT = 8
);
    logic [IO_COUNT-1:0] tx_data_i;
    logic                tx_valid_i;
    logic                tx_ready_o;
    logic [IO_COUNT-1:0] rx_data_o;
    logic                rx_err_o;
    logic                rx_valid_o;
    logic                rx_ready_i;
    logic                ovf_o;

    modport slave (
        input  tx_data_i, tx_valid_i, rx_ready_i,
        output tx_ready_o, rx_data_o, rx_err_o, rx_valid_o, ovf_o
    );

    modport master (
        output tx_data_i, tx_valid_i, rx_ready_i,
        input  tx_ready_o, rx_data_o, rx_err_o, rx_valid_o, ovf_o
    );
endinterface

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: system-clock controller for the SPI slave IO shift register.
//   clk_i, rstn_i       : system clock, async active-low reset
//   nss_i, sck_i        : raw SPI pins, synchronized internally
//   slv_data_i          : slave's latched frame word
//   slv_data_o          : parallel load word, only changed between frames
//   host                : tx/rx valid-ready streams plus overflow pulse
//   busy_o, frame_cnt_o : frame in progress, completed-frame count
`timescale 1ns/1ps
module spi_slave_ctrl #(
    parameter int IO_COUNT    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 2,
    parameter int FCNT_BITS   = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 nss_i,
    input  logic                 sck_i,
    input  logic [IO_COUNT-1:0]  slv_data_i,
    output logic [IO_COUNT-1:0]  slv_data_o,
    spi_slave_ctrl_if.slave      host,
    output logic                 busy_o,
    output logic [FCNT_BITS-1:0] frame_cnt_o
);
    localparam int BW = $clog2(2 * IO_COUNT + 1);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, SETTLE, CAPTURE} state_t;

    logic [SYNC_STAGES-1:0] nss_sync_q, nss_sync_d, sck_sync_q, sck_sync_d;
    logic                   nss_dly_q, nss_dly_d, sck_dly_q, sck_dly_d;
    state_t                 state_q, state_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]          settle_q, settle_d;
    logic [IO_COUNT-1:0]    stage_q, stage_d, slv_q, slv_d, rx_data_q, rx_data_d;
    logic                   stage_full_q, stage_full_d;
    logic                   rx_err_q, rx_err_d, rx_valid_q, rx_valid_d;
    logic                   ovf_q, ovf_d, busy_q, busy_d;
    logic [FCNT_BITS-1:0]   fcnt_q, fcnt_d;
    logic                   nss_s, sck_s, nss_rise, sck_rise;

    assign nss_s    = nss_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign nss_rise = nss_s & ~nss_dly_q;
    assign sck_rise = sck_s & ~sck_dly_q;

    always_comb begin
        nss_sync_d   = {nss_sync_q[SYNC_STAGES-2:0], nss_i};
        sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], sck_i};
        nss_dly_d    = nss_s;
        sck_dly_d    = sck_s;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        settle_d     = settle_q;
        stage_d      = stage_q;
        stage_full_d = stage_full_q;
        slv_d        = slv_q;
        rx_data_d    = rx_data_q;
        rx_err_d     = rx_err_q;
        rx_valid_d   = rx_valid_q & ~host.rx_ready_i;
        ovf_d        = 1'b0;
        fcnt_d       = fcnt_q;
        case (state_q)
            // Level test (not the fall pulse) so a frame that started during
            // SETTLE/CAPTURE is still picked up here.
            IDLE: if (!nss_s) begin
                state_d   = ACTIVE;
                bit_cnt_d = '0;
            end
            ACTIVE: begin
                if (sck_rise && bit_cnt_q != BW'(2 * IO_COUNT))
                    bit_cnt_d = bit_cnt_q + 1'b1;
                if (nss_rise) begin
                    state_d  = SETTLE;
                    settle_d = SW'(SETTLE_CYC - 1);
                end
            end
            SETTLE: begin
                state_d  = (settle_q == '0) ? CAPTURE : SETTLE;
                settle_d = (settle_q == '0) ? settle_q : settle_q - 1'b1;
            end
            CAPTURE: begin
                rx_data_d  = slv_data_i;
                rx_err_d   = (bit_cnt_q != BW'(IO_COUNT));
                rx_valid_d = 1'b1;
                ovf_d      = rx_valid_q & ~host.rx_ready_i;
                fcnt_d     = fcnt_q + 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Staging is full while a word waits, so accept and release never coincide.
        if (host.tx_valid_i && !stage_full_q) begin
            stage_d      = host.tx_data_i;
            stage_full_d = 1'b1;
        end else if (state_q == IDLE && nss_s && stage_full_q) begin
            slv_d        = stage_q;
            stage_full_d = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            nss_sync_q   <= '1;
            sck_sync_q   <= '0;
            nss_dly_q    <= 1'b1;
            sck_dly_q    <= 1'b0;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            settle_q     <= '0;
            stage_q      <= '0;
            stage_full_q <= 1'b0;
            slv_q        <= '0;
            rx_data_q    <= '0;
            rx_err_q     <= 1'b0;
            rx_valid_q   <= 1'b0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b0;
            fcnt_q       <= '0;
        end else begin
            nss_sync_q   <= nss_sync_d;
            sck_sync_q   <= sck_sync_d;
            nss_dly_q    <= nss_dly_d;
            sck_dly_q    <= sck_dly_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            settle_q     <= settle_d;
            stage_q      <= stage_d;
            stage_full_q <= stage_full_d;
            slv_q        <= slv_d;
            rx_data_q    <= rx_data_d;
            rx_err_q     <= rx_err_d;
            rx_valid_q   <= rx_valid_d;
            ovf_q        <= ovf_d;
            busy_q       <= busy_d;
            fcnt_q       <= fcnt_d;
        end
    end

    assign slv_data_o      = slv_q;
    assign host.tx_ready_o = ~stage_full_q;
    assign host.rx_data_o  = rx_data_q;
    assign host.rx_err_o   = rx_err_q;
    assign host.rx_valid_o = rx_valid_q;
    assign host.ovf_o      = ovf_q;
    assign busy_o          = busy_q;
    assign frame_cnt_o     = fcnt_q;
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: scoreboard bench for spi_slave_ctrl (IO_COUNT=8, SCK = clk/8).
`timescale 1ns/1ps
module tb_spi_slave_ctrl;
    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        nss = 1'b1;
    logic        sck = 1'b0;
    logic [7:0]  slv_data_i = '0;
    logic [7:0]  slv_data_o;
    logic        busy_o;
    logic [15:0] frame_cnt_o;
    int          n_chk = 0;
    int          n_err = 0;

    typedef struct packed {logic [7:0] d; logic e; logic o;} exp_t;
    exp_t q[$];

    spi_slave_ctrl_if #(.IO_COUNT(8)) hif ();

    spi_slave_ctrl #(.IO_COUNT(8), .SYNC_STAGES(2), .SETTLE_CYC(2), .FCNT_BITS(16)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .nss_i(nss), .sck_i(sck),
        .slv_data_i(slv_data_i), .slv_data_o(slv_data_o), .host(hif.slave),
        .busy_o(busy_o), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: each frame-count step pops one expected capture.
    logic [15:0] prev_cnt = '0;
    logic [15:0] exp_cnt = '0;
    always @(negedge clk) begin
        if (!rstn_i) begin
            prev_cnt = frame_cnt_o;
            exp_cnt  = '0;
        end else if (frame_cnt_o != prev_cnt) begin
            exp_t e;
            prev_cnt = frame_cnt_o;
            exp_cnt  = exp_cnt + 16'd1;
            if (q.size() == 0) chk("unexpected_capture", 1, 0);
            else begin
                e = q.pop_front();
                chk("rx_data", hif.rx_data_o, e.d);
                chk("rx_err", hif.rx_err_o, e.e);
                chk("rx_valid", hif.rx_valid_o, 1);
                chk("ovf", hif.ovf_o, e.o);
                chk("frame_cnt", frame_cnt_o, exp_cnt);
            end
        end
    end

    task automatic sck_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            sck = 1'b1;
            repeat (4) @(posedge clk);
            #1 sck = 1'b0;
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input int nbits, input logic [7:0] w, input bit exp_ovf,
                         input bit rdy_cap, input bit do_tx, input logic [7:0] txw);
        logic [15:0] c0;
        logic [7:0]  s0;
        s0 = slv_data_o;
        @(posedge clk);
        #1 nss = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("busy_active", busy_o, 1);
        sck_pulses(nbits);
        if (do_tx) begin
            hif.tx_data_i = txw;
            hif.tx_valid_i = 1'b1;
            @(posedge clk);
            #1 hif.tx_valid_i = 1'b0;
            chk("tx_ready_staged", hif.tx_ready_o, 0);
            chk("slv_hold_active", slv_data_o, s0);
        end
        q.push_back('{d: w, e: (nbits != 8), o: exp_ovf});
        slv_data_i = w;
        c0 = frame_cnt_o;
        nss = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("lat_early", frame_cnt_o, c0);
        if (rdy_cap) hif.rx_ready_i = 1'b1;
        @(posedge clk);
        #1 chk("lat_capture", frame_cnt_o, 16'(c0 + 16'd1));
        if (rdy_cap) hif.rx_ready_i = 1'b0;
        if (do_tx) begin
            chk("slv_hold_capture", slv_data_o, s0);
            chk("tx_ready_hold", hif.tx_ready_o, 0);
        end
        @(posedge clk);
        #1 chk("ovf_one_cycle", hif.ovf_o, 0);
        chk("busy_idle", busy_o, 0);
        chk("drain", q.size(), 0);
        if (do_tx) begin
            chk("slv_applied", slv_data_o, txw);
            chk("tx_ready_back", hif.tx_ready_o, 1);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hif.tx_data_i = '0;
        hif.tx_valid_i = 1'b0;
        hif.rx_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_ready", hif.tx_ready_o, 1);
        chk("rst_rx_valid", hif.rx_valid_o, 0);
        chk("rst_slv", slv_data_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_fcnt", frame_cnt_o, 0);
        chk("rst_ovf", hif.ovf_o, 0);
        rstn_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // Normal frame, tx staged in IDLE beforehand.
        hif.tx_data_i = 8'hA5;
        hif.tx_valid_i = 1'b1;
        @(posedge clk);
        #1 hif.tx_valid_i = 1'b0;
        chk("tx_ready_after_hs", hif.tx_ready_o, 0);
        repeat (2) @(posedge clk);
        #1 chk("slv_pre_frame", slv_data_o, 8'hA5);
        chk("tx_ready_idle", hif.tx_ready_o, 1);
        frame(8, 8'h3C, 0, 0, 0, 8'h00);
        // Short and long frames.
        frame(5, 8'h77, 0, 0, 0, 8'h00);
        frame(12, 8'h81, 0, 0, 0, 8'h00);
        // Overrun, then ready exactly on CAPTURE with a pending word.
        hif.rx_ready_i = 1'b0;
        frame(8, 8'h11, 0, 0, 0, 8'h00);
        frame(8, 8'h22, 1, 0, 0, 8'h00);
        frame(8, 8'h33, 0, 1, 0, 8'h00);
        chk("pending_valid", hif.rx_valid_o, 1);
        chk("pending_data", hif.rx_data_o, 8'h33);
        hif.rx_ready_i = 1'b1;
        @(posedge clk);
        #1 chk("consumed", hif.rx_valid_o, 0);
        // TX handshake while ACTIVE is deferred until IDLE.
        frame(8, 8'h44, 0, 0, 1, 8'h5A);
        // Reset mid-frame, released with NSS still low.
        @(posedge clk);
        #1 nss = 1'b0;
        repeat (4) @(posedge clk);
        #1 sck_pulses(3);
        chk("busy_before_rst", busy_o, 1);
        rstn_i = 1'b0;
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_slv", slv_data_o, 0);
        chk("mid_rst_fcnt", frame_cnt_o, 0);
        chk("mid_rst_tx_ready", hif.tx_ready_o, 1);
        chk("mid_rst_rx_valid", hif.rx_valid_o, 0);
        chk("mid_rst_rx_data", hif.rx_data_o, 0);
        repeat (3) @(posedge clk);
        #1 rstn_i = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("busy_after_release", busy_o, 1);
        sck_pulses(4);
        q.push_back('{d: 8'h99, e: 1'b1, o: 1'b0});
        slv_data_i = 8'h99;
        nss = 1'b1;
        for (int i = 0; i < 30 && q.size() != 0; i++) @(posedge clk);
        #1 chk("rst_frame_drain", q.size(), 0);
        chk("rst_frame_cnt", frame_cnt_o, 1);
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
